// File: rtl/aibnd_clkgate_pkg.sv
// aibnd_clkgate_pkg: shared state encoding and parameter defaults for the clock-gate controller
package aibnd_clkgate_pkg;
   localparam int CNT_W_DEF     = 4;
   localparam int DRAIN_CYC_DEF = 4;
   localparam int WAKE_CYC_DEF  = 2;
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_GATED = 2'd2;
   localparam logic [1:0] ST_WAKE  = 2'd3;
endpackage

// File: rtl/aibnd_clkgate_ctl.sv
// aibnd_clkgate_ctl: drain/gate/wake sequencer producing a registered enable for an aibnd_nor2 clock gate
module aibnd_clkgate_ctl
   import aibnd_clkgate_pkg::*;
#(
   parameter int DRAIN_CYC = DRAIN_CYC_DEF,
   parameter int WAKE_CYC  = WAKE_CYC_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic gate_req,
   input  logic busy,
   input  logic vccl_aibnd,
   input  logic vssl_aibnd,
   output logic en,
   output logic gate_ack
);
   localparam logic [CNT_W-1:0] DRAIN_N = CNT_W'(DRAIN_CYC);
   localparam logic [CNT_W-1:0] WAKE_N  = CNT_W'(WAKE_CYC);
   logic [1:0] state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic en_q, en_d, ack_q, ack_d;
   logic unused_pwr;
   assign unused_pwr = vccl_aibnd ^ vssl_aibnd;
   always_comb begin
      cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: if (gate_req) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
         end
         ST_DRAIN: begin
            // abort outranks the final drain count
            if (!gate_req) state_d = ST_RUN;
            else if (busy) cnt_d = '0;
            else if (cnt_inc == DRAIN_N) state_d = ST_GATED;
            else cnt_d = cnt_inc;
         end
         ST_GATED: if (!gate_req) begin
            state_d = ST_WAKE;
            cnt_d   = '0;
         end
         default: begin
            if (cnt_inc == WAKE_N) state_d = ST_RUN;
            else cnt_d = cnt_inc;
         end
      endcase
      en_d  = state_d == ST_GATED;
      ack_d = en_d | (state_d == ST_WAKE);
   end
   // outputs come straight from rising-edge flops so en never moves while clk is low
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         ack_q   <= ack_d;
      end
   end
   assign en       = en_q;
   assign gate_ack = ack_q;
endmodule
